// File: rtl/mcycle_scheduler.sv
// Issues one MUL/DIV to the multi-cycle unit, tracks its destination for decode hazards,
// and slips the result onto the register-file write port when the pipeline is not writing.
module mcycle_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  Start_MCycle,
    input  logic                  MCycleOp_MCycle,
    input  logic [3:0]            Rd_D,
    input  logic [3:0]            RA1_D,
    input  logic [3:0]            RA2_D,
    input  logic [3:0]            RA3_D,
    input  logic                  RegW_D,
    input  logic [3:0]            WA_D,
    input  logic [DATA_WIDTH-1:0] Operand1,
    input  logic [DATA_WIDTH-1:0] Operand2,
    input  logic                  MC_Busy,
    input  logic [DATA_WIDTH-1:0] MC_Result,
    output logic                  MC_Start,
    output logic                  MC_Op,
    output logic [DATA_WIDTH-1:0] MC_Operand1,
    output logic [DATA_WIDTH-1:0] MC_Operand2,
    input  logic                  RegW_P,
    input  logic [3:0]            WA_P,
    input  logic [DATA_WIDTH-1:0] WD_P,
    output logic                  WE3,
    output logic [3:0]            A3,
    output logic [DATA_WIDTH-1:0] WD3,
    output logic                  Stall_D,
    output logic                  Err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  start_q, start_d;
    logic                  op_q, op_d;
    logic [DATA_WIDTH-1:0] opnd1_q, opnd1_d;
    logic [DATA_WIDTH-1:0] opnd2_q, opnd2_d;
    logic [3:0]            pend_rd_q, pend_rd_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  pending_s;
    logic                  hazard_s;

    // Decode hazard detection: conservative match of every source field and the destination.
    always_comb begin
        pending_s = (state_q != S_IDLE);
        hazard_s  = (RA1_D == pend_rd_q) || (RA2_D == pend_rd_q) || (RA3_D == pend_rd_q)
                  || (RegW_D && (WA_D == pend_rd_q));
        Stall_D   = pending_s && (Start_MCycle || hazard_s);
    end

    // Next-state logic for the issue/wait/write-back sequencer.
    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        op_d      = op_q;
        opnd1_d   = opnd1_q;
        opnd2_d   = opnd2_q;
        pend_rd_d = pend_rd_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (Start_MCycle && !Stall_D) begin
                    // R15 is the PC; such an issue is flagged and dropped.
                    if (Rd_D == 4'd15) begin
                        err_d = 1'b1;
                    end else begin
                        op_d      = MCycleOp_MCycle;
                        opnd1_d   = Operand1;
                        opnd2_d   = Operand2;
                        pend_rd_d = Rd_D;
                        start_d   = 1'b1;
                        state_d   = S_START;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                cnt_d   = {CNT_W{1'b0}};
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!MC_Busy && (cnt_q >= CNT_W'(1))) begin
                    buf_d   = MC_Result;
                    state_d = S_WB;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WB: begin
                if (!RegW_P) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            op_q      <= 1'b0;
            opnd1_q   <= {DATA_WIDTH{1'b0}};
            opnd2_q   <= {DATA_WIDTH{1'b0}};
            pend_rd_q <= 4'd0;
            buf_q     <= {DATA_WIDTH{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            op_q      <= op_d;
            opnd1_q   <= opnd1_d;
            opnd2_q   <= opnd2_d;
            pend_rd_q <= pend_rd_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    // Write-port merge: the pipeline always wins, the buffered result fills an idle slot.
    always_comb begin
        if ((state_q == S_WB) && !RegW_P) begin
            WE3 = 1'b1;
            A3  = pend_rd_q;
            WD3 = buf_q;
        end else begin
            WE3 = RegW_P;
            A3  = WA_P;
            WD3 = WD_P;
        end
    end

    assign MC_Start    = start_q;
    assign MC_Op       = op_q;
    assign MC_Operand1 = opnd1_q;
    assign MC_Operand2 = opnd2_q;
    assign Err         = err_q;

endmodule
